// File: rtl/mux_pkg.sv
// Shared encodings for the stream multiplexer family.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the first set request at or after ptr wins.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_vld
);

    localparam int unsigned SW1 = SW + 1;

    logic [SW:0]   sum;
    logic [SW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest request overwrites last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int unsigned off = N; off > 0; off--) begin
            sum = {1'b0, ptr} + SW1'(off - 1);
            if (sum >= SW1'(N)) begin
                sum = sum - SW1'(N);
            end
            idx = sum[SW-1:0];
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mux_stream_n.sv
// N-channel valid/ready stream mux with fixed or round-robin arbitration and one
// registered output stage.
module mux_stream_n
    import mux_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 8,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready
);

    logic          load;
    logic          fx_vld;
    logic          rr_vld;
    logic          grant_valid;
    logic [SW-1:0] rr_idx;
    logic [SW-1:0] grant;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_next;
    logic [W-1:0]  grant_data;

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    always_comb begin
        load   = !out_valid || out_ready;
        fx_vld = 1'b0;
        // A sel value with no matching channel (sel >= N) simply never grants.
        for (int unsigned k = 0; k < N; k++) begin
            if (sel == SW'(k) && in_valid[k]) begin
                fx_vld = 1'b1;
            end
        end
        grant       = (mode == MODE_RR) ? rr_idx : sel;
        grant_valid = rst_n && load && ((mode == MODE_RR) ? rr_vld : fx_vld);

        in_ready   = '0;
        grant_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (grant == SW'(k)) begin
                in_ready[k] = grant_valid;
                grant_data  = in_data[k*W +: W];
            end
        end
        ptr_next = (grant == SW'(N - 1)) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (grant_valid) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant;
            ptr       <= ptr_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_stream_n.sv
// Directed and randomized checks of mux_stream_n against a cycle-level reference model.
module tb_mux_stream_n;
    import mux_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           mode = MODE_RR;
    logic [SW-1:0]  sel = '0;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready = 1'b0;

    logic [W-1:0] pl [N];

    always_comb begin
        for (int k = 0; k < N; k++) in_data[k*W +: W] = pl[k];
    end

    always #5 clk = ~clk;

    mux_stream_n #(
        .N  (N),
        .W  (W),
        .SW (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Reference model: one held beat plus "next channel to search from".
    int           m_ptr;
    bit           m_vld;
    logic [W-1:0] m_data;
    int           m_ch;
    int           sb_ch[$];
    logic [W-1:0] sb_data[$];
    int           passed = 0;
    int           failed = 0;
    int           total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_grant(output bit gv, output int g);
        gv = 0;
        g  = 0;
        if (mode == MODE_RR) begin
            for (int k = 0; k < N; k++) begin
                if (!gv && in_valid[(m_ptr + k) % N]) begin
                    gv = 1;
                    g  = (m_ptr + k) % N;
                end
            end
        end else if (int'(sel) < N && in_valid[sel]) begin
            gv = 1;
            g  = int'(sel);
        end
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_vld  = 0;
        m_data = '0;
        m_ch   = 0;
        sb_ch.delete();
        sb_data.delete();
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic cycle(input string tag);
        bit           gv;
        int           g;
        bit           load;
        bit           hs;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        if (!rst_n) model_reset();
        load = !m_vld || out_ready;
        model_grant(gv, g);
        hs      = rst_n && load && gv;
        exp_rdy = '0;
        if (hs) exp_rdy[g] = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        chk({tag, ".onehot"}, 32'($onehot0(in_ready)), 32'd1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
        if (m_vld) begin
            chk({tag, ".out_data"}, 32'(out_data), 32'(m_data));
            chk({tag, ".out_ch"}, 32'(out_ch), 32'(m_ch));
        end
        if (rst_n && m_vld && out_ready) begin
            if (sb_ch.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                chk({tag, ".sb_ch"}, 32'(out_ch), 32'(sb_ch.pop_front()));
                chk({tag, ".sb_data"}, 32'(out_data), 32'(sb_data.pop_front()));
            end
        end
        if (hs) begin
            sb_ch.push_back(g);
            sb_data.push_back(pl[g]);
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (hs) begin
            m_vld  = 1;
            m_data = pl[g];
            m_ch   = g;
            m_ptr  = (g + 1) % N;
        end else if (m_vld && out_ready) begin
            m_vld = 0;
        end
        #1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) pl[k] = 8'hA0 + 8'(k);
        model_reset();

        // Reset with every channel requesting.
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #2;
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        cycle("rst");
        rst_n = 1'b1;

        // Round-robin fairness, one beat per cycle.
        for (int i = 0; i < 8; i++) begin
            cycle("rr");
            chk("rr.valid", 32'(out_valid), 32'd1);
            chk("rr.seq_ch", 32'(out_ch), 32'(i % 4));
            chk("rr.seq_data", 32'(out_data), 32'(8'hA0 + 8'(i % 4)));
        end

        // Fixed select on channel 2.
        mode = MODE_FIXED;
        sel  = 2'd2;
        for (int i = 0; i < 4; i++) begin
            cycle("fix");
            chk("fix.ch", 32'(out_ch), 32'd2);
            chk("fix.data", 32'(out_data), 32'hA2);
        end
        in_valid = 4'b1011;
        #1;
        chk("fix.nogrant", 32'(in_ready), 32'd0);
        cycle("fix_drain");
        chk("fix.drained", 32'(out_valid), 32'd0);
        cycle("fix_idle");
        chk("fix.idle", 32'(out_valid), 32'd0);

        // Backpressure holds the beat and blocks all inputs.
        sel      = 2'd0;
        pl[0]    = 8'h5C;
        in_valid = 4'b0001;
        cycle("bp_load");
        chk("bp.loaded", 32'(out_data), 32'h5C);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle("bp_hold");
            chk("bp.data", 32'(out_data), 32'h5C);
            chk("bp.valid", 32'(out_valid), 32'd1);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 4'b0000;
        cycle("bp_release");
        chk("bp.no_dup", 32'(out_valid), 32'd0);

        // Mode switch: RR ch1, fixed ch3, then RR resumes at ch0.
        mode     = MODE_RR;
        in_valid = 4'b0010;
        cycle("ms_rr1");
        chk("ms.ch1", 32'(out_ch), 32'd1);
        mode     = MODE_FIXED;
        sel      = 2'd3;
        in_valid = 4'b1000;
        cycle("ms_fix3");
        chk("ms.ch3", 32'(out_ch), 32'd3);
        mode     = MODE_RR;
        in_valid = 4'b1111;
        cycle("ms_rr0");
        chk("ms.ch0", 32'(out_ch), 32'd0);

        // Sparse random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            mode      = ($urandom_range(0, 3) == 0) ? MODE_FIXED : MODE_RR;
            sel       = SW'($urandom_range(0, N - 1));
            out_ready = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < N; k++) begin
                in_valid[k] = ($urandom_range(0, 2) == 0);
                pl[k]       = W'($urandom);
            end
            cycle("rand");
        end

        // Drain everything; every accepted beat must have come out exactly once.
        in_valid  = '0;
        out_ready = 1'b1;
        cycle("drain");
        cycle("drain");
        chk("drain.sb_size", 32'(sb_ch.size()), 32'd0);
        chk("drain.out_valid", 32'(out_valid), 32'd0);

        // Reset mid-operation discards the held beat.
        mode      = MODE_RR;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        cycle("mid_load");
        chk("mid.loaded", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.async_clear", 32'(out_valid), 32'd0);
        chk("mid.in_ready", 32'(in_ready), 32'd0);
        cycle("mid_rst");
        rst_n    = 1'b1;
        in_valid = 4'b1111;
        cycle("mid_after");
        chk("mid.first_ch0", 32'(out_ch), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux_stream_n.md
# mux_stream_n

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes, selectable fixed-select or round-robin arbitration, and one registered output stage. It is the sequential, handshaked successor to the combinational 4:1 mux: it merges several producer streams onto one consumer port without dropping or duplicating beats.

## Interface
- `N`, default 4: number of input channels; must be ≥ 2.
- `W`, default 8: data width per channel.
- `SW`, default `$clog2(N)`: select and channel-ID width; derived, do not override.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset. One clock domain. Reset is asynchronous and active-low.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  SW  channel to pass in fixed mode; ignored in round-robin mode.
- `in_data`  in  N*W  channel k occupies bits [k*W +: W].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready; at most one bit high per cycle.
- `out_data`  out  W  registered output data.
- `out_ch`  out  SW  registered source channel of `out_data`.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  consumer ready.

## Operation
- Output register: holds one beat. `load = !out_valid | out_ready`.
- Grant (combinational) is computed only when `load` = 1.
  - Fixed mode: grant channel `sel` if `in_valid[sel]`. Otherwise, or if `sel` ≥ N, there is no grant.
  - Round-robin mode: grant the first channel with `in_valid` set, searching `ptr`, `ptr+1`, … `N-1`, `0`, … (mod N).
- `in_ready[g] = load & grant_valid & (g == grant)`. All other bits are 0.
- Input handshake on channel g (`in_valid[g] & in_ready[g]`):
  - `out_data <= in_data[g]`
  - `out_ch <= g`
  - `out_valid <= 1`
  - `ptr <= (g == N-1) ? 0 : g+1`
- Output consumed (`out_valid & out_ready`) with no new grant: `out_valid <= 0`. `out_data` and `out_ch` hold their last values.
- Simultaneous output drain and new grant: the register reloads in the same edge, giving no bubble.
- `ptr` updates on every accepted beat in either mode. A fixed-mode grant therefore moves `ptr`, and round-robin resumes after the last served channel.
- A change of `mode` or `sel` takes effect for the arbitration in the same cycle. It never disturbs a beat already held in the output register.
- `in_valid` deasserting without a handshake is a legal no-op. The block never requires a channel to hold valid.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `ptr` = 0, `in_ready` = 0. Reset is applied asynchronously; deassertion is synchronous to `clk` at the system level.
- Reset mid-operation: a beat held in the output register is discarded. No `in_ready` is asserted while `rst_n` = 0.
- Latency: input handshake at edge t gives `out_valid` = 1 after edge t. That is one cycle.
- Throughput: 1 beat per cycle with `out_ready` held at 1.
- Backpressure: with `out_valid` = 1 and `out_ready` = 0, `in_ready` is all-zero and `out_data`/`out_ch` are stable.
- `in_ready` depends combinationally on `out_ready`, `in_valid`, `mode` and `sel`. There is no combinational path from `in_data` to any output.

## Structure
- Shared package `mux_pkg`: mode encodings `MODE_FIXED` = 1'b0 and `MODE_RR` = 1'b1.
- Sub-module `rr_pick #(N)`: inputs `req[N]` and `ptr[SW]`; outputs `gnt_idx[SW]` and `gnt_vld`. It is a purely combinational rotating priority picker, built with a double-width request vector or an equivalent loop.
- Top level contains the output register, `ptr`, the fixed/round-robin grant mux and the `in_ready` decode.

## Test plan
- Reset: with `rst_n` = 0 and all `in_valid` = 1111, expect `in_ready` = 0000 and `out_valid` = 0. After release, the first grant in round-robin mode goes to ch0.
- Round-robin fairness: N = 4, all valid continuously, `out_ready` = 1. Expect `out_ch` sequence 0,1,2,3,0,1… with `out_data` equal to the per-channel payloads 8'hA0..8'hA3. Expect one beat per cycle with no gaps.
- Fixed select: `mode` = 0, `sel` = 2, all valid. Expect only `in_ready[2]` pulses and `out_ch` = 2 on every beat. With `sel` = 2 and `in_valid` = 1011, expect no grant and `out_valid` to drop after drain.
- Backpressure: hold `out_ready` = 0 for 5 cycles after a beat with `out_data` = 8'h5C. Expect `out_data` to hold 8'h5C, `in_ready` = 0000, and no beat lost or duplicated when `out_ready` returns.
- Mode switch: in round-robin mode, serve ch1, then switch to fixed with `sel` = 3 for one beat, then switch back. The next round-robin grant is ch0, because `ptr` wrapped from 3.
- Sparse requests with random `out_ready`: a scoreboard checks the per-channel order and the count of all beats. It also checks that `in_ready` is one-hot or zero in every cycle.
